// File: rtl/vbfs_gather_pipe_pkg.sv
// Shared widths and the per-node BFS state record for the gather pipeline.
// Imported by the interface, the top and the bench.
package vbfs_pkg;
    localparam int DEF_NODEID_W = 32;
    localparam int DEF_LEVEL_W  = 32;
    localparam int DEF_CNT_W    = 16;

    typedef struct packed {
        logic [DEF_NODEID_W-1:0] parent;
        logic                    active;
        logic [DEF_LEVEL_W-1:0]  level;
    } state_t;
endpackage

// File: rtl/vbfs_gather_pipe_if.sv
// Message-in / state-out bus of the BFS gather pipeline; slave = the pipe, master = its driver.
interface vbfs_gather_pipe_if
    import vbfs_pkg::*;
#(
    parameter int NODEID_W = DEF_NODEID_W,
    parameter int LEVEL_W  = DEF_LEVEL_W
);
    logic                valid_in;
    logic                ready;
    logic [NODEID_W-1:0] nodeid_in;
    logic [NODEID_W-1:0] sender_in;
    logic [LEVEL_W-1:0]  level_in;
    logic [NODEID_W-1:0] state_in_parent;
    logic                state_in_active;
    logic [LEVEL_W-1:0]  state_in_level;
    logic                state_valid;
    logic                state_ack;
    logic [NODEID_W-1:0] nodeid_out;
    logic [NODEID_W-1:0] state_out_parent;
    logic                state_out_active;
    logic [LEVEL_W-1:0]  state_out_level;

    modport slave (
        input  valid_in, nodeid_in, sender_in, level_in,
               state_in_parent, state_in_active, state_in_level, state_ack,
        output ready, state_valid, nodeid_out, state_out_parent,
               state_out_active, state_out_level
    );

    modport master (
        output valid_in, nodeid_in, sender_in, level_in,
               state_in_parent, state_in_active, state_in_level, state_ack,
        input  ready, state_valid, nodeid_out, state_out_parent,
               state_out_active, state_out_level
    );
endinterface

// File: rtl/vbfs_gather_pipe_skid_buf.sv
// 2-entry valid/ready skid buffer, generic payload width.
// Latency 1 cycle when empty; in_rdy_o is registered (occupancy < 2), never depends on out_rdy_i.
module vbfs_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         rdy_q, rdy_d;
    logic         push, pop;

    assign push      = in_vld_i & rdy_q;
    assign pop       = out_vld_o & out_rdy_i;
    assign in_rdy_o  = rdy_q;
    assign out_vld_o = (cnt_q != 2'd0);
    assign out_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_dat_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        // Ready for next cycle comes from next occupancy, so it stays a pure flop output.
        rdy_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            rdy_q    <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
        end
    end
endmodule

// File: rtl/vbfs_gather_pipe.sv
// BFS gather: merges an incoming message into stored node state; 1-cycle latency via skid buffer.
// Backpressure: ready is registered (low when 2 updates buffered). VBFS_GATHER_FWD_EN enables last-update forwarding.
module vbfs_gather_pipe
    import vbfs_pkg::*;
#(
    parameter int NODEID_W = DEF_NODEID_W,
    parameter int LEVEL_W  = DEF_LEVEL_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    vbfs_gather_pipe_if.slave bus,
    output logic [CNT_W-1:0] visited_count,
    output logic             err_sender0
);
    localparam int PAY_W = 2 * NODEID_W + 1 + LEVEL_W;

    logic                in_xfer;
    logic [NODEID_W-1:0] eff_parent;
    logic                eff_active;
    logic [LEVEL_W-1:0]  eff_level;
    logic [NODEID_W-1:0] upd_parent;
    logic                upd_active;
    logic [LEVEL_W-1:0]  upd_level;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [PAY_W-1:0]    pay_in, pay_out;

    assign in_xfer = bus.valid_in & bus.ready;

`ifdef VBFS_GATHER_FWD_EN
    logic                fwd_vld_q;
    logic [NODEID_W-1:0] fwd_node_q;
    logic [NODEID_W-1:0] fwd_parent_q;
    logic                fwd_active_q;
    logic [LEVEL_W-1:0]  fwd_level_q;

    // Back-to-back updates to one node: the state RAM has not seen the previous write yet.
    always_comb begin
        eff_parent = bus.state_in_parent;
        eff_active = bus.state_in_active;
        eff_level  = bus.state_in_level;
        if (fwd_vld_q && (fwd_node_q == bus.nodeid_in)) begin
            eff_parent = fwd_parent_q;
            eff_active = fwd_active_q;
            eff_level  = fwd_level_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fwd_vld_q    <= 1'b0;
            fwd_node_q   <= '0;
            fwd_parent_q <= '0;
            fwd_active_q <= 1'b0;
            fwd_level_q  <= '0;
        end else if (in_xfer) begin
            fwd_vld_q    <= 1'b1;
            fwd_node_q   <= bus.nodeid_in;
            fwd_parent_q <= upd_parent;
            fwd_active_q <= upd_active;
            fwd_level_q  <= upd_level;
        end
    end
`else
    assign eff_parent = bus.state_in_parent;
    assign eff_active = bus.state_in_active;
    assign eff_level  = bus.state_in_level;
`endif

    always_comb begin
        upd_parent = eff_parent;
        upd_active = eff_active;
        upd_level  = eff_level;
        cnt_d      = cnt_q;
        err_d      = err_q;
        if (eff_parent == '0) begin
            upd_parent = bus.sender_in;
            upd_active = 1'b1;
            upd_level  = bus.level_in;
            if (in_xfer) begin
                if (bus.sender_in == '0) begin
                    err_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign pay_in = {bus.nodeid_in, upd_parent, upd_active, upd_level};

    vbfs_skid_buf #(
        .W(PAY_W)
    ) u_skid (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .in_vld_i  (bus.valid_in),
        .in_rdy_o  (bus.ready),
        .in_dat_i  (pay_in),
        .out_vld_o (bus.state_valid),
        .out_rdy_i (bus.state_ack),
        .out_dat_o (pay_out)
    );

    assign {bus.nodeid_out, bus.state_out_parent, bus.state_out_active, bus.state_out_level} = pay_out;
    assign visited_count = cnt_q;
    assign err_sender0   = err_q;
endmodule
